// File: rtl/inst_mem_loader_pkg.sv
// Shared definitions for the instruction-memory programming path: widths,
// memory depth and the loader FSM state encoding.
package inst_mem_loader_pkg;

    localparam int PC_BITS        = 8;
    localparam int BYTE_SIZE      = 8;
    localparam int INST_MEM_DEPTH = 56;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_DATA     = 3'd2,
        S_W_SETUP  = 3'd3,
        S_W_STROBE = 3'd4,
        S_W_HOLD   = 3'd5
    } loader_state_t;

    // States in which a byte can be taken from the I2C slave
    function automatic logic accepts_byte(input loader_state_t s);
        return (s == S_IDLE) || (s == S_ADDR) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/inst_mem_loader.sv
// Instruction-memory loader: turns an I2C byte frame (start address byte,
// then data bytes) into setup/strobe/hold writes on the byte-wide memory
// port, and holds the core while a frame is open.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int MEM_DEPTH = INST_MEM_DEPTH,
    parameter int ADDR_W    = PC_BITS,
    parameter int DATA_W    = BYTE_SIZE
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rx_start,
    input  logic              i_rx_stop,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    output logic              o_rx_ready,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [DATA_W-1:0] o_mem_data,
    output logic              o_mem_cs,
    output logic              o_cpu_hold,
    output logic [ADDR_W-1:0] o_byte_count,
    output logic              o_err_ovf
);

    localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(MEM_DEPTH);

    loader_state_t     r_state;
    loader_state_t     w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_data;
    logic [ADDR_W-1:0] r_byte_count;
    logic              r_rx_ready;
    logic              r_mem_cs;
    logic              r_cpu_hold;
    logic              r_err_ovf;
    logic              r_start_pend;
    logic              r_stop_pend;
    logic              w_take;
    logic              w_in_range;

    assign w_take     = i_rx_valid & r_rx_ready;
    assign w_in_range = (r_addr < LP_DEPTH);

    // Next-state decode; a start always reopens the frame, ahead of a stop
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_rx_start) w_next = w_take ? S_DATA : S_ADDR;
            end
            S_ADDR: begin
                if (i_rx_start)     w_next = w_take ? S_DATA : S_ADDR;
                else if (i_rx_stop) w_next = S_IDLE;
                else if (w_take)    w_next = S_DATA;
            end
            S_DATA: begin
                if (i_rx_start)     w_next = w_take ? S_DATA : S_ADDR;
                else if (w_take)    w_next = S_W_SETUP;
                else if (i_rx_stop) w_next = S_IDLE;
            end
            S_W_SETUP:  w_next = S_W_STROBE;
            S_W_STROBE: w_next = S_W_HOLD;
            S_W_HOLD: begin
                if (r_start_pend || i_rx_start)    w_next = S_ADDR;
                else if (r_stop_pend || i_rx_stop) w_next = S_IDLE;
                else                               w_next = S_DATA;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // FSM state, datapath registers and registered output decode
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_mem_address <= '0;
            r_mem_data    <= '0;
            r_byte_count  <= '0;
            r_rx_ready    <= 1'b0;
            r_mem_cs      <= 1'b0;
            r_cpu_hold    <= 1'b0;
            r_err_ovf     <= 1'b0;
            r_start_pend  <= 1'b0;
            r_stop_pend   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= accepts_byte(w_next);
            r_cpu_hold <= (w_next != S_IDLE);
            // strobe only for in-range targets; r_addr is stable through the write
            r_mem_cs   <= (w_next == S_W_STROBE) && w_in_range;

            case (r_state)
                S_IDLE, S_ADDR, S_DATA: begin
                    r_start_pend <= 1'b0;
                    r_stop_pend  <= 1'b0;
                    if (i_rx_start) begin
                        r_byte_count <= '0;
                        r_err_ovf    <= 1'b0;
                        if (w_take) r_addr <= ADDR_W'(i_rx_data);
                    end else if (r_state == S_ADDR && w_take && !i_rx_stop) begin
                        r_addr <= ADDR_W'(i_rx_data);
                    end else if (r_state == S_DATA && w_take) begin
                        r_mem_address <= r_addr;
                        r_mem_data    <= i_rx_data;
                        // a stop arriving with the byte closes the frame after the write
                        r_stop_pend   <= i_rx_stop;
                    end
                end
                S_W_SETUP, S_W_STROBE: begin
                    if (i_rx_start) r_start_pend <= 1'b1;
                    if (i_rx_stop)  r_stop_pend  <= 1'b1;
                    if (r_state == S_W_STROBE && !w_in_range) r_err_ovf <= 1'b1;
                end
                S_W_HOLD: begin
                    r_addr       <= r_addr + 1'b1;
                    r_start_pend <= 1'b0;
                    r_stop_pend  <= 1'b0;
                    if (r_start_pend || i_rx_start) begin
                        r_byte_count <= '0;
                        r_err_ovf    <= 1'b0;
                    end else if (w_in_range && r_byte_count != '1) begin
                        r_byte_count <= r_byte_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_rx_ready    = r_rx_ready;
    assign o_mem_address = r_mem_address;
    assign o_mem_data    = r_mem_data;
    assign o_mem_cs      = r_mem_cs;
    assign o_cpu_hold    = r_cpu_hold;
    assign o_byte_count  = r_byte_count;
    assign o_err_ovf     = r_err_ovf;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: expected memory writes are queued as bytes are
// sent and compared when the strobe appears.
module tb_inst_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_start = 1'b0;
    logic       rx_stop = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_cs;
    logic       cpu_hold;
    logic [7:0] byte_count;
    logic       err_ovf;

    int n_chk = 0;
    int n_fail = 0;
    int n_cs = 0;
    logic [15:0] exp_q[$];
    logic       prev_cs = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    inst_mem_loader dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_start   (rx_start),
        .i_rx_stop    (rx_stop),
        .i_rx_valid   (rx_valid),
        .i_rx_data    (rx_data),
        .o_rx_ready   (rx_ready),
        .o_mem_address(mem_address),
        .o_mem_data   (mem_data),
        .o_mem_cs     (mem_cs),
        .o_cpu_hold   (cpu_hold),
        .o_byte_count (byte_count),
        .o_err_ovf    (err_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // expected write model: only in-range addresses produce a strobe
    task automatic exp_write(input logic [7:0] a, input logic [7:0] d);
        if (a < 8'd56) exp_q.push_back({a, d});
    endtask

    // write monitor: scoreboard pop plus address/data stability around the strobe
    always @(negedge clk) begin
        if (prev_cs) begin
            chk("hold_addr", mem_address, prev_addr);
            chk("hold_data", mem_data, prev_data);
        end
        if (mem_cs) begin
            chk("setup_addr", mem_address, prev_addr);
            chk("setup_data", mem_data, prev_data);
            if (exp_q.size() == 0) begin
                chk("unexpected_cs", 1, 0);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                chk("wr_addr", mem_address, e[15:8]);
                chk("wr_data", mem_data, e[7:0]);
            end
        end
        n_cs      <= n_cs + (mem_cs ? 1 : 0);
        prev_cs   <= mem_cs;
        prev_addr <= mem_address;
        prev_data <= mem_data;
    end

    // called at a negedge; returns at the negedge after the transfer edge
    task automatic send_byte(input logic [7:0] b, output int waits);
        waits = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!rx_ready) chk("ready_timeout", 0, 1);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        rx_start = 1'b1;
        @(negedge clk);
        rx_start = 1'b0;
    endtask

    task automatic pulse_stop();
        rx_stop = 1'b1;
        @(negedge clk);
        rx_stop = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (cpu_hold && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_fall", cpu_hold, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, rx_ready, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_data"}, mem_data, 0);
        chk({tag, "_cs"}, mem_cs, 0);
        chk({tag, "_hold"}, cpu_hold, 0);
        chk({tag, "_count"}, byte_count, 0);
        chk({tag, "_err"}, err_ovf, 0);
    endtask

    initial begin
        int w;
        int cs0;
        logic [7:0] d;

        // reset state
        repeat (3) @(negedge clk);
        chk_all_zero("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", rx_ready, 1);
        chk("idle_hold", cpu_hold, 0);

        // 1: four writes from address 0
        cs0 = n_cs;
        pulse_start();
        chk("t1_hold_open", cpu_hold, 1);
        send_byte(8'h00, w);
        for (int i = 0; i < 4; i++) begin
            d = 8'hAA + 8'(i * 8'h11);
            exp_write(8'(i), d);
            send_byte(d, w);
        end
        rx_valid = 1'b0;
        chk("t1_hold_in_write", cpu_hold, 1);
        pulse_stop();
        wait_idle();
        chk("t1_count", byte_count, 4);
        chk("t1_err", err_ovf, 0);
        chk("t1_ncs", n_cs - cs0, 4);
        chk("t1_q", exp_q.size(), 0);

        // 2: run off the end of memory
        cs0 = n_cs;
        pulse_start();
        send_byte(8'h36, w);
        for (int i = 0; i < 3; i++) begin
            d = 8'h11 * 8'(i + 1);
            exp_write(8'h36 + 8'(i), d);
            send_byte(d, w);
        end
        rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        pulse_stop();
        wait_idle();
        chk("t2_count", byte_count, 2);
        chk("t2_err", err_ovf, 1);
        chk("t2_ncs", n_cs - cs0, 2);

        // 3: stop during the strobe; write completes, nothing follows
        cs0 = n_cs;
        pulse_start();
        send_byte(8'h05, w);
        exp_write(8'h05, 8'h77);
        send_byte(8'h77, w);
        rx_valid = 1'b0;
        @(negedge clk);
        chk("t3_strobe", mem_cs, 1);
        pulse_stop();
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        repeat (2) @(negedge clk);
        chk("t3_hold", cpu_hold, 0);
        repeat (8) @(negedge clk);
        rx_valid = 1'b0;
        chk("t3_ncs", n_cs - cs0, 1);
        chk("t3_count", byte_count, 1);

        // 4: start together with the address byte
        cs0 = n_cs;
        rx_start = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h10;
        @(negedge clk);
        rx_start = 1'b0;
        exp_write(8'h10, 8'h5A);
        send_byte(8'h5A, w);
        chk("t4_ready_wait", w, 0);
        rx_valid = 1'b0;
        pulse_stop();
        wait_idle();
        chk("t4_ncs", n_cs - cs0, 1);
        chk("t4_count", byte_count, 1);

        // 5: reset during setup aborts the write
        cs0 = n_cs;
        pulse_start();
        send_byte(8'h20, w);
        send_byte(8'h99, w);
        rx_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("t5");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5_ncs", n_cs - cs0, 0);

        // 6: valid held high; ready 1,0,0,0 per byte
        cs0 = n_cs;
        pulse_start();
        send_byte(8'h30, w);
        for (int i = 0; i < 4; i++) begin
            d = 8'h01 + 8'(i);
            exp_write(8'h30 + 8'(i), d);
            send_byte(d, w);
            chk("t6_ready_gap", w, (i == 0) ? 0 : 3);
        end
        rx_valid = 1'b0;
        pulse_stop();
        wait_idle();
        chk("t6_count", byte_count, 4);
        chk("t6_ncs", n_cs - cs0, 4);
        chk("end_q", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
